// File: rtl/meduram_lvt_mwnr_pkg.sv
// ---------------------------------------------------------------------------
// meduram_pkg
// Shared sizing helpers for the multi-write / multi-read LVT RAM.
//   MAX_PORTS  : largest supported number of write or read ports.
//   lvt_width  : bits needed to name one write port in a Live-Value Table
//                entry (never less than one bit).
// The LVT entry type itself is declared in the top from lvt_width, because
// its width depends on the top's NB_WPORT parameter.
// ---------------------------------------------------------------------------
package meduram_pkg;

  localparam int MAX_PORTS = 8;

  // A single write port still needs a one-bit entry so the table exists.
  function automatic int lvt_width(input int nb_wport);
    return (nb_wport <= 1) ? 1 : $clog2(nb_wport);
  endfunction

endpackage

// File: rtl/meduram_lvt_mwnr_if.sv
// ---------------------------------------------------------------------------
// meduram_lvt_mwnr_if
// Bundles the write/read bus of meduram_lvt_mwnr.
//   wren / wraddr / wrdata  : per-write-port enable, packed address, packed data
//   rden / rdaddr           : per-read-port enable, packed address
//   rddata / rdvalid        : per-read-port packed data and valid strobe
//   wr_collision            : one-cycle pulse on same-address writes
// master drives requests (testbench / user); slave is the RAM.
// ---------------------------------------------------------------------------
interface meduram_lvt_mwnr_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int NB_WPORT   = 2,
  parameter int NB_RPORT   = 2
);

  logic [NB_WPORT-1:0]            wren;
  logic [NB_WPORT*ADDR_WIDTH-1:0] wraddr;
  logic [NB_WPORT*DATA_WIDTH-1:0] wrdata;
  logic [NB_RPORT-1:0]            rden;
  logic [NB_RPORT*ADDR_WIDTH-1:0] rdaddr;
  logic [NB_RPORT*DATA_WIDTH-1:0] rddata;
  logic [NB_RPORT-1:0]            rdvalid;
  logic                           wr_collision;

  modport master (
    output wren, wraddr, wrdata, rden, rdaddr,
    input  rddata, rdvalid, wr_collision
  );

  modport slave (
    input  wren, wraddr, wrdata, rden, rdaddr,
    output rddata, rdvalid, wr_collision
  );

endinterface

// File: rtl/meduram_lvt_mwnr_bank.sv
// ---------------------------------------------------------------------------
// meduram_bank_1w1r
// Simple dual-port bank: one write port, one read port with a registered
// output. The array and the output register are not reset. A read and a
// write to the same address in one cycle return the old contents.
//   clk_i            : rising-edge clock
//   we_i/waddr_i/wdata_i : write port
//   re_i/raddr_i     : read request; rdata_o updates only when re_i is high
//   rdata_o          : registered read data, held while re_i is low
// ---------------------------------------------------------------------------
module meduram_bank_1w1r #(
  parameter int ADDR_WIDTH = 8,
  parameter int RAM_DEPTH  = 2**ADDR_WIDTH,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Callers only assert we_i/re_i for in-range addresses.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/meduram_lvt_mwnr.sv
// ---------------------------------------------------------------------------
// meduram_lvt_mwnr
// NB_WPORT-write / NB_RPORT-read RAM built from NB_WPORT*NB_RPORT 1W1R banks
// and a Live-Value Table recording which write port last wrote each address.
// Reads have one cycle of latency; out-of-range writes are dropped and
// out-of-range reads return zero with rdvalid set.
//   aclk     : rising-edge clock
//   aresetn  : asynchronous active-low reset (LVT, read outputs, collision)
//   port_if  : meduram_lvt_mwnr_if.slave bus (wren/wraddr/wrdata,
//              rden/rdaddr, rddata/rdvalid, wr_collision)
// Optional: define MEDURAM_WR_BYPASS_EN for write-first reads (a read that
// matches a same-cycle write returns the highest-index writer's data).
// ---------------------------------------------------------------------------
module meduram_lvt_mwnr
  import meduram_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int RAM_DEPTH  = 2**ADDR_WIDTH,
  parameter int DATA_WIDTH = 32,
  parameter int NB_WPORT   = 2,
  parameter int NB_RPORT   = 2
) (
  input  logic aclk,
  input  logic aresetn,
  meduram_lvt_mwnr_if.slave port_if
);

  localparam int LVTW = lvt_width(NB_WPORT);
  typedef logic [LVTW-1:0] lvt_t;

  // One extra bit so a full 2**ADDR_WIDTH depth is representable.
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH+1)'(RAM_DEPTH);

  logic [ADDR_WIDTH-1:0] wrAddr [NB_WPORT];
  logic [DATA_WIDTH-1:0] wrData [NB_WPORT];
  logic [NB_WPORT-1:0]   wrAct;
  logic [ADDR_WIDTH-1:0] rdAddr [NB_RPORT];
  logic [NB_RPORT-1:0]   rdInRange;

  lvt_t                  lvtTable_q [RAM_DEPTH];
  lvt_t                  rdSel_q [NB_RPORT];
  logic [NB_RPORT-1:0]   rdValid_q;
  logic [NB_RPORT-1:0]   rdUseBank_q;
  logic                  wrCollision_q;
  logic                  wrCollision_d;

  logic [DATA_WIDTH-1:0]          bankRdata [NB_WPORT][NB_RPORT];
  logic [DATA_WIDTH-1:0]          rdWord;
  logic [NB_RPORT*DATA_WIDTH-1:0] rdDataMux;

  // Unpack the bus; a write is only "active" when its address is in range.
  always_comb begin
    for (int i = 0; i < NB_WPORT; i++) begin
      wrAddr[i] = port_if.wraddr[i*ADDR_WIDTH +: ADDR_WIDTH];
      wrData[i] = port_if.wrdata[i*DATA_WIDTH +: DATA_WIDTH];
      wrAct[i]  = port_if.wren[i] && ({1'b0, wrAddr[i]} < DEPTH_LIM);
    end
    for (int r = 0; r < NB_RPORT; r++) begin
      rdAddr[r]    = port_if.rdaddr[r*ADDR_WIDTH +: ADDR_WIDTH];
      rdInRange[r] = {1'b0, rdAddr[r]} < DEPTH_LIM;
    end
  end

  // Any pair of active writes to one address raises the collision pulse.
  always_comb begin
    wrCollision_d = 1'b0;
    for (int i = 0; i < NB_WPORT; i++)
      for (int j = i + 1; j < NB_WPORT; j++)
        if (wrAct[i] && wrAct[j] && (wrAddr[i] == wrAddr[j]))
          wrCollision_d = 1'b1;
  end

  // Ascending loop: the highest active port's entry is the one that lands.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int a = 0; a < RAM_DEPTH; a++) lvtTable_q[a] <= '0;
    end else begin
      for (int i = 0; i < NB_WPORT; i++)
        if (wrAct[i]) lvtTable_q[wrAddr[i]] <= lvt_t'(i);
    end
  end

  // Every write port owns one bank per read port.
  for (genvar w = 0; w < NB_WPORT; w++) begin : g_wr
    for (genvar r = 0; r < NB_RPORT; r++) begin : g_rd
      meduram_bank_1w1r #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RAM_DEPTH  (RAM_DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
      ) u_bank (
        .clk_i   (aclk),
        .we_i    (wrAct[w]),
        .waddr_i (wrAddr[w]),
        .wdata_i (wrData[w]),
        .re_i    (port_if.rden[r] && rdInRange[r]),
        .raddr_i (rdAddr[r]),
        .rdata_o (bankRdata[w][r])
      );
    end
  end

  // rdUseBank_q low means "drive zero": after reset or an out-of-range read.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int r = 0; r < NB_RPORT; r++) rdSel_q[r] <= '0;
      rdValid_q     <= '0;
      rdUseBank_q   <= '0;
      wrCollision_q <= 1'b0;
    end else begin
      for (int r = 0; r < NB_RPORT; r++) begin
        if (port_if.rden[r]) begin
          rdValid_q[r]   <= 1'b1;
          rdUseBank_q[r] <= rdInRange[r];
          rdSel_q[r]     <= rdInRange[r] ? lvtTable_q[rdAddr[r]] : '0;
        end else begin
          rdValid_q[r]   <= 1'b0;
        end
      end
      wrCollision_q <= wrCollision_d;
    end
  end

`ifdef MEDURAM_WR_BYPASS_EN
  logic [NB_RPORT-1:0]   bypHit_q;
  logic [NB_RPORT-1:0]   bypHit_d;
  logic [DATA_WIDTH-1:0] bypData_q [NB_RPORT];
  logic [DATA_WIDTH-1:0] bypData_d [NB_RPORT];

  // A matching active write implies an in-range read address.
  always_comb begin
    for (int r = 0; r < NB_RPORT; r++) begin
      bypHit_d[r]  = 1'b0;
      bypData_d[r] = '0;
      for (int w = 0; w < NB_WPORT; w++)
        if (wrAct[w] && (wrAddr[w] == rdAddr[r])) begin
          bypHit_d[r]  = 1'b1;
          bypData_d[r] = wrData[w];
        end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      bypHit_q <= '0;
      for (int r = 0; r < NB_RPORT; r++) bypData_q[r] <= '0;
    end else begin
      for (int r = 0; r < NB_RPORT; r++)
        if (port_if.rden[r]) begin
          bypHit_q[r]  <= bypHit_d[r];
          bypData_q[r] <= bypData_d[r];
        end
    end
  end
`endif

  // Select the live bank per read port; bypass data overrides when captured.
  always_comb begin
    rdDataMux = '0;
    rdWord    = '0;
    for (int r = 0; r < NB_RPORT; r++) begin
      rdWord = '0;
      if (rdUseBank_q[r])
        for (int w = 0; w < NB_WPORT; w++)
          if (rdSel_q[r] == lvt_t'(w)) rdWord = bankRdata[w][r];
`ifdef MEDURAM_WR_BYPASS_EN
      if (bypHit_q[r]) rdWord = bypData_q[r];
`endif
      rdDataMux[r*DATA_WIDTH +: DATA_WIDTH] = rdWord;
    end
  end

  assign port_if.rddata       = rdDataMux;
  assign port_if.rdvalid      = rdValid_q;
  assign port_if.wr_collision = wrCollision_q;

endmodule

// File: doc/meduram_lvt_mwnr.md
Name: meduram_lvt_mwnr

Overview:
- Parametrised multi-ported RAM with NB_WPORT write ports and NB_RPORT read ports; successor to the fixed 2W/2R top.
- Built from NB_WPORT x NB_RPORT simple 1W/1R banks plus a Live-Value Table (LVT). The LVT records, per address, which write port last wrote it.
- Read ports return the live copy with one cycle of registered latency.
- Adds a write-collision flag, a read-valid strobe and an optional write-first bypass.

Parameters:
- ADDR_WIDTH, 8, address bits per port.
- RAM_DEPTH, 2**ADDR_WIDTH, words per bank; must be <= 2**ADDR_WIDTH.
- DATA_WIDTH, 32, bits per word.
- NB_WPORT, 2, number of write ports, 1..8.
- NB_RPORT, 2, number of read ports, 1..8.

Ports:
- aclk  in  1  clock; all logic rising-edge.
- aresetn  in  1  asynchronous active-low reset.
- wren  in  NB_WPORT  per-port write enable.
- wraddr  in  NB_WPORT*ADDR_WIDTH  packed write addresses; port i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- wrdata  in  NB_WPORT*DATA_WIDTH  packed write data.
- rden  in  NB_RPORT  per-port read enable.
- rdaddr  in  NB_RPORT*ADDR_WIDTH  packed read addresses.
- rddata  out  NB_RPORT*DATA_WIDTH  packed read data.
- rdvalid  out  NB_RPORT  rddata slice valid strobe.
- wr_collision  out  1  pulse: two or more enabled write ports targeted the same address in the same cycle.

Behaviour:
- Reset (aresetn low, async):
  - rddata = 0, rdvalid = 0, wr_collision = 0.
  - All LVT entries = 0, i.e. every address points at write port 0's banks.
  - Bank contents are not reset; reading a never-written address returns unspecified data.
  - Deassertion is synchronised by the integrator; the block itself samples inputs from the first rising edge with aresetn high.
- Write, cycle N, wren[i]=1:
  - Bank[i][r] is written for every r at wraddr_i.
  - LVT[wraddr_i] <= i.
  - Both updates are visible to reads issued at N+1.
- Write collision:
  - Several enabled ports with equal addresses in cycle N: the highest port index wins both bank data and LVT entry.
  - Lower ports still write their own banks, but those banks are no longer live.
  - wr_collision = 1 during cycle N+1 only; independent pairs OR together.
- Read, cycle N, rden[r]=1:
  - Bank[*][r] and LVT are sampled at rdaddr_r.
  - At N+1, rddata_r = bank[LVT value][r] output and rdvalid[r] = 1.
  - Fixed latency 1; back-to-back reads every cycle supported.
- rden[r]=0: rddata_r holds its last value and rdvalid[r] = 0 the next cycle.
- Read-during-write, same address, same cycle: read-first by default; returns the value before the write.
- Address >= RAM_DEPTH: write ignored (no bank or LVT update, no collision counted); read returns 0 with rdvalid = 1.
- LVT width is max(1, clog2(NB_WPORT)). Addresses wrap nowhere; no internal counters beyond LVT state.

Optional Feature:
- Macro MEDURAM_WR_BYPASS_EN.
- Defined (write-first): a read in cycle N whose address matches an enabled write in cycle N returns that write data at N+1. If several writes match, the highest-index writer's data is returned. Implemented as a registered comparator/mux per read port.
- Undefined (read-first): no bypass logic is built.

Decomposition:
- Package meduram_pkg holds:
  - function lvt_width(nb_wport);
  - localparam MAX_PORTS = 8;
  - typedef of the LVT entry (parametrised via function; package holds the sizing function only).
- Sub-module meduram_bank_1w1r: ADDR_WIDTH/RAM_DEPTH/DATA_WIDTH, one write port, one registered read port, no reset on the array.
  - Instantiated NB_WPORT*NB_RPORT times via a generate loop.
- LVT, collision detection and output muxing stay in meduram_lvt_mwnr.

Test Plan (ADDR_WIDTH=8, DATA_WIDTH=32, NB_WPORT=2, NB_RPORT=2):
- Basic write/read: port0 writes 0x10=0xDEADBEEF at cycle 0; port1 reads 0x10 at cycle 1. Expect rddata1=0xDEADBEEF and rdvalid[1]=1 at cycle 2, rdvalid[0]=0.
- LVT tracking: port0 writes 0x20=0x11111111, then port1 writes 0x20=0x22222222. Both read ports read 0x20 in the same cycle; both return 0x22222222.
- Collision: both ports write 0x30 in one cycle (0xAAAA0000, 0xBBBB0000). Expect wr_collision=1 for exactly one cycle; subsequent reads of 0x30 return 0xBBBB0000.
- Read-during-write: 0x40 holds 0x0000000A; port0 writes 0x0000000B while port0 reads 0x40. Expect 0x0000000A without the macro, 0x0000000B with MEDURAM_WR_BYPASS_EN.
- Reset mid-operation, after the LVT scenario:
  - Drop aresetn while continuous reads are in flight. Expect rddata=0, rdvalid=0 and wr_collision=0 immediately, without waiting for aclk.
  - After release, read 0x20: returns 0x11111111, since the LVT points at port0's banks again.
- Out-of-range depth (RAM_DEPTH=200): writing 0xD0 changes nothing; a read of 0xD0 returns 0 with rdvalid=1.
